data_bus_bridge: RTL
====================

DATA_BUS_BRIDGE -- requirements
Module: data_bus_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles in ISSUE+RDWAIT before forced completion with error (1..65535).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cpu_address  in  32  CPU data byte address.
REQ-005 cpu_read  in  1  CPU read request, held until cpu_waitrequest low.
REQ-006 cpu_write  in  1  CPU write request, held until cpu_waitrequest low.
REQ-007 cpu_writedata  in  32  write data.
REQ-008 cpu_byteenable  in  4  write byte lanes; ignored for reads.
REQ-009 cpu_readdata  out  32  read data, valid only in RESP.
REQ-010 cpu_waitrequest  out  1  CPU stall; high while a request is outstanding.
REQ-011 avm_address  out  32  word-aligned memory address.
REQ-012 avm_read / avm_write  out  1 each  memory strobes.
REQ-013 avm_writedata  out  32; avm_byteenable  out  4  (4'b1111 on reads).
REQ-014 avm_waitrequest  in  1  memory not accepting; strobe held while high.
REQ-015 avm_readdata  in  32; avm_readdatavalid  in  1  read return, >=1 cycle after acceptance.
REQ-016 bus_error  out  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, ISSUE, RDWAIT, RESP; exactly one active.
REQ-018 IDLE, cpu_read XOR cpu_write: capture address {cpu_address[31:2],2'b00}, writedata, byteenable, direction into registers -> ISSUE.
REQ-019 IDLE, write with cpu_byteenable==0: no bus cycle -> RESP directly.
REQ-020 IDLE, cpu_read AND cpu_write: no bus cycle, set bus_error, cpu_readdata=0 -> RESP.
REQ-021 ISSUE: avm_read or avm_write high from registered values; held stable while avm_waitrequest high.
REQ-022 ISSUE, avm_waitrequest low: write -> RESP; read -> RDWAIT; strobe deasserts next cycle.
REQ-023 RDWAIT: first cycle with avm_readdatavalid high latches avm_readdata into cpu_readdata -> RESP; readdatavalid in other states ignored.
REQ-024 RESP lasts exactly one cycle, cpu_waitrequest low, then -> IDLE.
REQ-025 cpu_waitrequest = (cpu_read OR cpu_write) AND state != RESP (combinational).
REQ-026 Timeout counter: cleared on entry to ISSUE, +1 per cycle in ISSUE/RDWAIT; at TIMEOUT_CYCLES: drop strobes, set bus_error, cpu_readdata=0 -> RESP.
REQ-027 Counter saturates, never wraps.
REQ-028 bus_error, once set, stays high until reset.
REQ-029 Min latency (zero-wait memory, readdatavalid next cycle): read request cycle N -> RESP N+3; write -> RESP N+2.
REQ-030 avm_read and avm_write never both high; strobes only in ISSUE.
REQ-031 cpu_address[1:0] do not affect avm_address; byte-lane selection is the CPU's responsibility.
REQ-032 One outstanding transaction max; new requests sampled only in IDLE.

Reset
REQ-033 reset low asynchronously: state IDLE, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, cpu_readdata=0, counter=0, bus_error=0.
REQ-034 Reset mid-transaction abandons it; strobes drop immediately; no response; late readdatavalid after release ignored.
REQ-035 reset rise: first sampling edge in IDLE; cpu_waitrequest follows REQ-025 immediately.

Verification
REQ-036 Read 0x1000_0006, zero-wait memory, readdatavalid 1 cycle later with 0xDEADBEEF -> avm_address 0x1000_0004, byteenable 4'b1111, RESP at N+3, cpu_readdata 0xDEADBEEF.
REQ-037 Write 0x2000_0000, data 0x0000_00AB, byteenable 4'b0001, avm_waitrequest high 3 cycles -> avm_write held 4 cycles, stable address/data/byteenable, RESP one cycle after acceptance, bus_error 0.
REQ-038 Read with memory never responding, TIMEOUT_CYCLES=8 -> strobe dropped after 8 cycles, RESP with cpu_readdata 0, bus_error 1 and sticky across later good transactions.
REQ-039 cpu_read and cpu_write both high -> no avm strobe, RESP next cycle, bus_error 1; zero-byteenable write -> RESP next cycle, no avm_write, bus_error unchanged.
REQ-040 reset low during RDWAIT, readdatavalid after release -> all outputs zero immediately, FSM IDLE, stale data not returned; next read completes normally.
REQ-041 Back-to-back reads held by CPU -> one IDLE cycle between transactions, no overlapping strobes.

Source files
------------

// File: rtl/data_bus_bridge.sv
// -----------------------------------------------------------------------------
// data_bus_bridge
//
// Bridges a simple CPU data port (held read/write request, waitrequest stall)
// onto an Avalon-MM style memory master with pipelined read return.
// One transaction is in flight at a time. Illegal requests (read and write
// together) and bus cycles that exceed TIMEOUT_CYCLES complete with a sticky
// bus_error and zero read data.
//
// Ports
//   clk                 single clock, all state on rising edge
//   reset               asynchronous, active-low
//   cpu_address         CPU byte address (bits [1:0] ignored on the bus)
//   cpu_read/cpu_write  CPU requests, held until cpu_waitrequest is low
//   cpu_writedata       write data
//   cpu_byteenable      write byte lanes (ignored for reads)
//   cpu_readdata        read data, valid in the response cycle
//   cpu_waitrequest     CPU stall
//   avm_address         word-aligned memory address
//   avm_read/avm_write  memory strobes
//   avm_writedata       memory write data
//   avm_byteenable      memory byte lanes (all ones on reads)
//   avm_waitrequest     memory not accepting
//   avm_readdata        memory read data
//   avm_readdatavalid   memory read return strobe
//   bus_error           sticky error flag
// -----------------------------------------------------------------------------
module data_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The counter holds the number of completed ISSUE/RDWAIT cycles, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        rd_dir;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign tmo_hit         = (tmo_cnt >= TMO_LAST);
  assign cpu_waitrequest = (cpu_read || cpu_write) && (state != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rd_dir         <= 1'b0;
      tmo_cnt        <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      cpu_readdata   <= '0;
      bus_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_read && cpu_write) begin
            bus_error    <= 1'b1;
            cpu_readdata <= '0;
            state        <= RESP;
          end else if (cpu_write && (cpu_byteenable == 4'b0000)) begin
            // Nothing to write: complete without touching the bus.
            state <= RESP;
          end else if (cpu_read || cpu_write) begin
            avm_address    <= cpu_address & 32'hFFFF_FFFC;
            avm_writedata  <= cpu_writedata;
            avm_byteenable <= cpu_read ? 4'b1111 : cpu_byteenable;
            avm_read       <= cpu_read;
            avm_write      <= cpu_write;
            rd_dir         <= cpu_read;
            tmo_cnt        <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          if (!avm_waitrequest && !rd_dir) begin
            avm_write <= 1'b0;
            state     <= RESP;
          end else if (tmo_hit) begin
            // A read accepted on the last budgeted cycle cannot return in
            // time, so it is abandoned together with a still-stalled strobe.
            avm_read     <= 1'b0;
            avm_write    <= 1'b0;
            bus_error    <= 1'b1;
            cpu_readdata <= '0;
            state        <= RESP;
          end else if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= RDWAIT;
          end
        end
        RDWAIT: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          if (avm_readdatavalid) begin
            cpu_readdata <= avm_readdata;
            state        <= RESP;
          end else if (tmo_hit) begin
            bus_error    <= 1'b1;
            cpu_readdata <= '0;
            state        <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
